// File: rtl/uart_rx_if.sv
// Receive-side byte port of the UART receiver: valid/ready handshake plus
// error reporting. The receiver is the master, the consumer is the slave.
interface uart_rx_if;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport master (
    output data_out, valid, frame_err, overrun, parity_err,
    input  ready
  );

  modport slave (
    input  data_out, valid, frame_err, overrun, parity_err,
    output ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, oversampled 8N1 (or 8E1/8O1 when UART_RX_PARITY_EN is
// defined). The line is synchronized, a fresh falling edge starts a frame,
// the start bit is confirmed at mid-bit and every following bit is sampled
// one full bit period later. Bytes are offered on a valid/ready port; a byte
// arriving before the previous one was taken overwrites it and sets overrun.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     enable_clk,
  input  logic     rx,
  uart_rx_if.master out_if
);

  localparam int TCW = $clog2(OVERSAMPLE);
  localparam logic [TCW-1:0] TC_HALF = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TC_FULL = TCW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           rx_meta_q, rx_meta_d;
  logic           rx_s_q, rx_s_d;
  logic           rx_q, rx_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           frame_err_q, frame_err_d;
  logic           overrun_q, overrun_d;
  logic           load;
  logic           stop_bad;
`ifdef UART_RX_PARITY_EN
  logic           par_bit_q, par_bit_d;
  logic           parity_err_q, parity_err_d;
`endif

  // Frame recovery: synchronizer, tick-qualified edge detector and the bit FSM.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_d      = rx_q;
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    load      = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d = par_bit_q;
`endif
    if (enable_clk) begin
      rx_d = rx_s_q;
      case (state_q)
        S_IDLE: begin
          if (rx_q && !rx_s_q) begin
            state_d = S_START;
            tcnt_d  = '0;
          end
        end
        S_START: begin
          if (tcnt_q == TC_HALF) begin
            tcnt_d = '0;
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              bcnt_d  = 3'd0;
            end
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
        S_DATA: begin
          if (tcnt_q == TC_FULL) begin
            tcnt_d          = '0;
            shift_d[bcnt_q] = rx_s_q;
            if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + 3'd1;
            end
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tcnt_q == TC_FULL) begin
            tcnt_d    = '0;
            par_bit_d = rx_s_q;
            state_d   = S_STOP;
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
`endif
        S_STOP: begin
          if (tcnt_q == TC_FULL) begin
            tcnt_d  = '0;
            state_d = S_IDLE;
            if (rx_s_q) begin
              load = 1'b1;
            end else begin
              stop_bad = 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output port: handshake retires the byte, a new load wins over retirement.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = stop_bad;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (valid_q && out_if.ready) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !out_if.ready) begin
        overrun_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      parity_err_d = ((^shift_q) ^ par_bit_q) != PARITY_ODD;
`endif
    end
  end

  // State registers; synchronizer and edge detector reset to the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_q        <= 1'b1;
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_q        <= rx_d;
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out_if.data_out  = data_q;
  assign out_if.valid     = valid_q;
  assign out_if.frame_err = frame_err_q;
  assign out_if.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign out_if.parity_err = parity_err_q;
`else
  assign out_if.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive-side companion of the existing 8N1 transmitter in the same design. It takes the asynchronous serial line `rx`, oversamples it with a shared baud-tick enable, and recovers 8-bit frames (1 start, 8 data LSB-first, 1 stop). Each received byte is presented on a valid/ready output port, with framing-error and overrun reporting.

## Interface
- `OVERSAMPLE`, default 16: `enable_clk` ticks per bit period. Must be an even number, at least 4.
- `PARITY_ODD`, default 0: parity sense, 0 = even, 1 = odd. Used only when the parity macro is defined.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `enable_clk`  in  1  one-`clk`-wide oversample tick at `OVERSAMPLE`× baud.
- `rx`  in  1  asynchronous serial input; idle high.
- `data_out`  out  8  received byte.
- `valid`  out  1  `data_out` holds an unconsumed byte.
- `ready`  in  1  consumer accepts the byte in the current cycle.
- `frame_err`  out  1  one-`clk` pulse when a stop bit is sampled low.
- `overrun`  out  1  sticky flag: an unconsumed byte was overwritten.
- `parity_err`  out  1  parity mismatch for the byte in `data_out`; tied 0 without the macro.

## Operation
- `rx` passes through a 2-FF synchronizer (`rx_s`), both stages reset to 1. A falling-edge detector `rx_q` is updated only on ticks.
- Tick counter `tcnt`, sized ceil(log2(OVERSAMPLE)), and bit counter `bcnt` (3 bits) advance only on `enable_clk`.
- States and transitions:
  - IDLE: on a tick where `rx_q`=1 and `rx_s`=0, go to START with `tcnt`=0.
  - START: on the tick where `tcnt`=OVERSAMPLE/2−1, sample `rx_s`. If it is 1 (glitch), go to IDLE. If it is 0, go to DATA with `tcnt`=0 and `bcnt`=0.
  - DATA: on the tick where `tcnt`=OVERSAMPLE−1, shift `rx_s` into bit `bcnt` (LSB first). After bit 7, go to PARITY (macro defined) or STOP.
  - PARITY: sample one bit at the same point and compute `parity_err`.
  - STOP: sample at `tcnt`=OVERSAMPLE−1.
    - 1: load `data_out`, set `valid`, go to IDLE.
    - 0: pulse `frame_err`, discard the byte, leave `valid`/`data_out` untouched, go to IDLE.
- IDLE requires a fresh 1→0 edge, so a line held low (break) never retriggers.
- Handshake: `valid` holds, with `data_out` stable, until a cycle with `valid`&&`ready`. `valid` falls the next cycle unless a new byte loads in that same cycle.
- New byte load while `valid`=1:
  - If `ready`=1 in that cycle: no overrun; `valid` stays 1 with the new data.
  - If `ready`=0: overwrite `data_out`, set `overrun`.
- `overrun` clears on the next accepted handshake.
- Reset values: `data_out`=0, `valid`=0, `frame_err`=0, `overrun`=0, `parity_err`=0, state IDLE, counters 0. Reset mid-frame aborts the frame with no output.

## Timing
- Synchronizer latency is 2 `clk`.
- `valid` rises on the `clk` edge after the stop-sample tick, about 9.5 bit periods (10.5 with parity) after the start edge.
- `frame_err` is high for exactly one `clk`, on the same edge `valid` would have risen.
- Ticks arriving while `valid`=1 do not stall reception; the receiver never backpressures the line.
- `ready` without `valid` is ignored.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 1 start, 8 data, 1 parity, 1 stop.
  - `parity_err` = (XOR of data bits and parity bit) != `PARITY_ODD`.
  - `parity_err` is registered alongside `data_out` and overwritten on each new byte load.
  - The byte is still delivered when `parity_err`=1.
- Macro undefined: 8N1 frame, no PARITY state, `parity_err` constant 0.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5 with `ready`=1 → one-cycle `valid`, `data_out`=0xA5, no error flags.
- `rx` low for 4 ticks, then high → START aborts, no `valid`, no `frame_err`, back in IDLE.
- Send 0x5A with the stop bit forced 0 → `frame_err` pulses once, `valid` stays 0; line held low for 3 more bit periods → no new frame.
- Send 0x3C then 0xC3 with `ready`=0 → `data_out`=0xC3, `overrun`=1; assert `ready` → `valid` and `overrun` clear next cycle.
- Assert `rst_n`=0 during bit 4 of 0xFF, release, send 0x81 → only 0x81 delivered.
- `UART_RX_PARITY_EN`, `PARITY_ODD`=0, send 0x07 with parity bit 1 → 0x07 delivered, `parity_err`=0; same byte with parity bit 0 → `parity_err`=1.
